// File: rtl/seq_101_tx.sv
// seq_101_tx
//   Serial frame transmitter feeding a "101" sequence-detecting receiver.
//   A word is accepted through a ready/load handshake. The frame is then
//   shifted out one bit per clock in this order:
//     - the preamble 1-0-1
//     - the payload, MSB first
//     - GAP idle zeros
//
// Parameters
//   DATA_W      payload width (1..32)
//   GAP         trailing idle-zero bits per frame (1..15)
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   data_in     payload word, sampled only on an accepted load
//   load        send request, accepted when load && ready at a rising edge
//   ready       idle and able to accept a load
//   dout        serial output bit (registered)
//   busy        a frame (preamble, data or gap) is being driven
//   frame_done  one-cycle pulse during the last gap bit of each frame
//
// Every output is a flop. The next-state logic computes the value each
// output must carry in the coming cycle. The first preamble bit therefore
// appears on dout on the same edge that accepts the load.

module seq_101_tx #(
    parameter int DATA_W = 8,
    parameter int GAP    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load,
    output logic              ready,
    output logic              dout,
    output logic              busy,
    output logic              frame_done
);

    // One counter is shared by all phases. It must reach the largest of
    // the preamble index (2), DATA_W-1 and GAP-1.
    localparam int CMAX  = (DATA_W > GAP) ? ((DATA_W > 3) ? DATA_W : 3)
                                          : ((GAP > 3) ? GAP : 3);
    localparam int CNT_W = $clog2(CMAX);

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(2);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              dout_d, busy_d, ready_d, fd_d;

    // State and output registers. Reset forces every output low at once,
    // including ready. ready only rises on the first edge after release,
    // because the IDLE branch below then requests it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            dout       <= 1'b0;
            busy       <= 1'b0;
            ready      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            dout       <= dout_d;
            busy       <= busy_d;
            ready      <= ready_d;
            frame_done <= fd_d;
        end
    end

    // Next-state logic. Each branch produces the output values for the
    // cycle that begins at the coming edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        dout_d  = 1'b0;
        busy_d  = 1'b1;
        ready_d = 1'b0;
        fd_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                // The registered ready gates acceptance. A load that arrives
                // while ready is still low after reset is therefore ignored.
                if (load && ready) begin
                    state_d = S_PRE;
                    cnt_d   = '0;
                    shreg_d = data_in;
                    dout_d  = 1'b1;        // preamble bit 0
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                end
            end

            S_PRE: begin
                if (cnt_q == PRE_LAST) begin
                    // The first payload bit goes out now. The register is
                    // shifted so that its MSB always holds the next bit to send.
                    state_d = S_DATA;
                    cnt_d   = '0;
                    dout_d  = shreg_q[DATA_W-1];
                    shreg_d = shreg_q << 1;
                end else begin
                    cnt_d  = cnt_q + CNT_ONE;
                    // Bit 0 is showing; the next bits are 0 and then 1.
                    dout_d = (cnt_q == CNT_ONE);
                end
            end

            S_DATA: begin
                if (cnt_q == DATA_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    dout_d  = 1'b0;
                    // With a single gap bit, the first gap cycle is also the last.
                    fd_d    = (GAP == 1);
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    dout_d  = shreg_q[DATA_W-1];
                    shreg_d = shreg_q << 1;
                end
            end

            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    fd_d  = ((cnt_q + CNT_ONE) == GAP_LAST);
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_101_tx.sv
// Testbench for seq_101_tx (DATA_W=8, GAP=2).
//
// A frame-level reference model predicts every output on every cycle. It
// builds a queue holding the whole frame when a load is accepted, and pops
// one entry per clock. Directed scenarios also capture the dout and
// frame_done streams and compare them against hand-written bit patterns.
// A small 101 detector listens to dout for the loopback scenario.

module tb_seq_101_tx;
    localparam int DATA_W = 8;
    localparam int GAP    = 2;

    logic              clk     = 1'b0;
    logic              rst     = 1'b0;
    logic              load    = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              ready, dout, busy, frame_done;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_101_tx #(.DATA_W(DATA_W), .GAP(GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .load       (load),
        .ready      (ready),
        .dout       (dout),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each queue entry is {dout, busy, frame_done} for one cycle of a frame.
    logic       m_ready = 1'b0, m_dout = 1'b0, m_busy = 1'b0, m_fd = 1'b0;
    logic [2:0] q[$];

    always @(posedge clk or negedge rst) begin
        logic [2:0] t;
        if (!rst) begin
            q.delete();
            m_ready = 1'b0; m_dout = 1'b0; m_busy = 1'b0; m_fd = 1'b0;
        end else begin
            if (q.size() == 0 && m_ready && load) begin
                for (int i = 0; i < 3; i++)        q.push_back({(i != 1), 1'b1, 1'b0});
                for (int i = DATA_W-1; i >= 0; i--) q.push_back({data_in[i], 1'b1, 1'b0});
                for (int g = 0; g < GAP; g++)      q.push_back({1'b0, 1'b1, (g == GAP-1)});
            end
            if (q.size() > 0) begin
                t = q.pop_front();
                {m_dout, m_busy, m_fd} = t;
                m_ready = 1'b0;
            end else begin
                m_dout = 1'b0; m_busy = 1'b0; m_fd = 1'b0; m_ready = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, taken shortly after each edge.
    always @(posedge clk) begin
        #2;
        chk("cyc_dout",  dout,       m_dout);
        chk("cyc_busy",  busy,       m_busy);
        chk("cyc_ready", ready,      m_ready);
        chk("cyc_done",  frame_done, m_fd);
    end

    // ---------------- 101 Moore detector on dout ----------------
    logic [1:0] dst = 2'd0;
    int         det_cnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            case (dst)
                2'd0: dst <= dout ? 2'd1 : 2'd0;
                2'd1: dst <= dout ? 2'd1 : 2'd2;
                2'd2: begin
                    dst <= dout ? 2'd3 : 2'd0;
                    if (dout) det_cnt <= det_cnt + 1;
                end
                default: dst <= dout ? 2'd1 : 2'd2;
            endcase
        end else begin
            dst <= 2'd0;
        end
    end

    // Request a frame and capture n samples of dout and frame_done, starting
    // at the accepting edge. The first sample lands in bit n-1 of the result.
    // With hold set, load stays high throughout. When ign_at > 0, load is
    // raised with data 8'hFF for three edges starting at edge ign_at.
    task automatic run(input logic [DATA_W-1:0] d, input int n, input bit hold,
                       input int ign_at, output logic [63:0] cd, output logic [63:0] cf);
        cd = '0;
        cf = '0;
        @(negedge clk);
        load    = 1'b1;
        data_in = d;
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (!hold) begin
                    if (ign_at > 0 && k >= ign_at && k < ign_at + 3) begin
                        load    = 1'b1;
                        data_in = 8'hFF;
                    end else begin
                        load = 1'b0;
                    end
                end
            end
            @(posedge clk);
            #2;
            cd = {cd[62:0], dout};
            cf = {cf[62:0], frame_done};
        end
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] cd, cf;
        int          det_base;

        // Reset and idle
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ready", ready, 1'b0);
        chk("rst_dout",  dout,  1'b0);
        chk("rst_busy",  busy,  1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("rel_ready", ready, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        chk("idle_dout", dout, 1'b0);

        // Single frame 8'hA5
        run(8'hA5, 13, 1'b0, 0, cd, cf);
        chk("a5_bits", cd[12:0], 13'b1011010010100);
        chk("a5_done", cf[12:0], 13'b0000000000001);
        @(posedge clk);
        #2;
        chk("a5_ready_after", ready, 1'b1);

        // Load of 8'hFF during the DATA phase of an 8'h00 frame is ignored
        run(8'h00, 13, 1'b0, 5, cd, cf);
        chk("ign_bits", cd[12:0], 13'b1010000000000);
        chk("ign_done", cf[12:0], 13'b0000000000001);
        repeat (3) @(posedge clk);
        #2;
        chk("ign_idle_busy", busy, 1'b0);

        // Back-to-back frames of 8'h81 with load held high
        run(8'h81, 27, 1'b1, 0, cd, cf);
        chk("b2b_bits", cd[26:0], {13'b1011000000100, 1'b0, 13'b1011000000100});
        chk("b2b_done", cf[26:0], {13'b0000000000001, 1'b0, 13'b0000000000001});
        chk("b2b_done_cnt", $countones(cf[26:0]), 2);
        repeat (2) @(posedge clk);

        // Asynchronous reset during preamble bit 0
        @(negedge clk);
        load    = 1'b1;
        data_in = 8'hA5;
        @(posedge clk);
        #2;
        chk("mid_pre0", dout, 1'b1);
        load = 1'b0;
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_dout",  dout,       1'b0);
        chk("mid_rst_busy",  busy,       1'b0);
        chk("mid_rst_ready", ready,      1'b0);
        chk("mid_rst_done",  frame_done, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        chk("mid_rel_ready", ready, 1'b1);
        run(8'hA5, 13, 1'b0, 0, cd, cf);
        chk("mid_a5_bits", cd[12:0], 13'b1011010010100);
        chk("mid_a5_done", cf[12:0], 13'b0000000000001);

        // Loopback into the 101 detector with an all-zero payload
        repeat (3) @(posedge clk);
        #2;
        det_base = det_cnt;
        run(8'h00, 13, 1'b0, 0, cd, cf);
        repeat (4) @(posedge clk);
        #2;
        chk("loop_detects", det_cnt - det_base, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_101_tx.md
# seq_101_tx

Serial frame transmitter that drives a single-bit stream for downstream "101" sequence-detecting receivers. It accepts a parallel data word through a ready/load handshake. It then shifts out a fixed preamble 1-0-1, the data word MSB first, and a programmable run of idle zeros, one bit per clock. It sits on the transmit side of the serial link, feeding the receiver's din input.

## Interface
- DATA_W, 8, payload width in bits; legal range 1..32
- GAP, 2, number of trailing idle-zero bits per frame; legal range 1..15
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- data_in  in  DATA_W  payload word; sampled only on an accepted load
- load  in  1  request to send data_in; accepted when load=1 and ready=1 at a rising edge
- ready  out  1  high when idle and able to accept load
- dout  out  1  serial output bit, registered
- busy  out  1  high while a frame (preamble, data or gap) is being driven
- frame_done  out  1  one-cycle pulse during the last gap bit of each frame

## Operation
- FSM states: IDLE, PRE, DATA, GAP.
  - Counters: bit index 0..2 for PRE, 0..DATA_W-1 for DATA, and 0..GAP-1 for GAP.
  - The shift register is DATA_W wide.
- IDLE
  - dout=0, busy=0, ready=1.
  - An accepted load captures data_in into the shift register.
  - On the same edge: state goes to PRE, dout=1 (preamble bit 0), busy=1, ready=0.
- PRE
  - Drives 1, 0, 1 on successive cycles.
  - After the third bit, the next edge goes to DATA and drives shreg[DATA_W-1].
- DATA
  - Each edge shifts the register left and drives the next MSB.
  - After DATA_W bits, the next edge goes to GAP with dout=0.
- GAP
  - dout=0 for GAP cycles.
  - frame_done=1 during the final gap cycle only.
  - The next edge goes to IDLE: ready=1, busy=0, frame_done=0.
- Load while ready=0: ignored; data_in is not sampled and the frame in flight is unaffected.
- Back-to-back frames: load held high is accepted on the first edge in IDLE. This gives one IDLE cycle of dout=0 between frames, in addition to the GAP zeros.
- Payload content is not filtered. A "101" inside the data is transmitted as-is, and receivers may detect it.
- Reset (rst=0, any time including mid-frame):
  - Immediately, without waiting for a clock edge: state=IDLE, dout=0, busy=0, ready=0, frame_done=0, shift register and counters cleared.
  - The frame in flight is discarded, not resumed.
  - ready rises on the first rising edge after rst returns high.

## Timing
- Frame length is 3 + DATA_W + GAP cycles, measured from the accepting edge to the edge that returns to IDLE.
- Latency from the accepting edge to the first preamble bit on dout is 0 cycles, because dout updates on that edge.
- All outputs are registered. No output depends combinationally on an input.
- Frame period with load held continuously high: 4 + DATA_W + GAP cycles.
- Output reset values: dout=0, ready=0, busy=0, frame_done=0.
- Edge cases:
  - DATA_W=1: the DATA state lasts exactly 1 cycle.
  - GAP=1: frame_done coincides with the single gap cycle.

## Test plan
- Reset and idle.
  - Stimulus: rst=0 for 2 cycles, then release.
  - Response: dout=0 and busy=0 throughout; ready=0 during reset and 1 one edge after release; dout stays 0 with no load.
- Single frame.
  - Stimulus: DATA_W=8, GAP=2, data_in=8'hA5, one-cycle load.
  - Response: dout = 1,0,1,1,0,1,0,0,1,0,1,0,0 (13 cycles); frame_done high only in cycle 13; ready high on the following edge.
- Ignored load.
  - Stimulus: load=1 with data_in=8'hFF issued during the DATA phase of an 8'h00 frame.
  - Response: dout = 1,0,1,0,0,0,0,0,0,0,0,0,0; the 8'hFF word is never sent.
- Back-to-back.
  - Stimulus: load held high with data_in=8'h81, covering two frames.
  - Response: two identical frames 1,0,1,1,0,0,0,0,0,0,1,0,0 separated by exactly one IDLE zero; frame period 14 cycles; two frame_done pulses.
- Reset mid-frame.
  - Stimulus: assert rst asynchronously between clock edges during the preamble bit 0 of an 8'hA5 frame.
  - Response: dout=0, busy=0 and ready=0 before the next edge; after release, ready=1 and a fresh frame sends the correct full sequence.
- Loopback.
  - Stimulus: connect dout to a 101 Moore detector and send 8'h00.
  - Response: exactly one detection, on the preamble.
